// File: rtl/mig_ui_model.sv
// Single-beat behavioural model of a MIG-style user interface.
// Byte-masked 128-bit memory, write-data FIFO, one pending-write slot and a fixed-latency read pipe.
module mig_ui_model #(
  parameter int DEPTH_LOG2   = 10,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 16,
  parameter int WDF_DEPTH    = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [26:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  input  logic         stall,
  output logic         app_rdy,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int PW    = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
  localparam int CW    = $clog2(WDF_DEPTH + 1);
  localparam logic [CW-1:0] WDF_FULL = CW'(WDF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(WDF_DEPTH - 1);
  localparam logic [7:0]    CAL_LAST = 8'(CALIB_CYCLES - 1);

  logic [7:0]            cal_cnt_q;
  logic                  calib_q;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [143:0]          fifo_mem [WDF_DEPTH];
  logic                  pend_q, pend_d;
  logic [DEPTH_LOG2-1:0] pend_idx_q, cmd_idx, wr_idx;
  logic                  fifo_nonempty, push, pop, wr_acc, rd_acc;
  logic [127:0]          head_data;
  logic [15:0]           head_mask;
  logic [127:0]          rd_word, rd_data_last;
  logic [RD_LATENCY-1:0] vld_q;
  logic                  unused_ok;

  // Outputs are forced low for the whole time reset is asserted, not only after its first edge.
  assign init_calib_complete = ~reset & calib_q;
  assign app_wdf_rdy         = ~reset & calib_q & (count_q < WDF_FULL);
  assign app_rdy             = ~reset & calib_q & ~stall & ~pend_q;

  assign cmd_idx       = app_addr[DEPTH_LOG2+3:4];
  assign wr_acc        = app_en & app_rdy & (app_cmd == 3'b000);
  assign rd_acc        = app_en & app_rdy & (app_cmd == 3'b001);
  assign push          = app_wdf_wren & app_wdf_rdy;
  assign fifo_nonempty = (count_q != '0);
  assign pop           = ~reset & fifo_nonempty & (wr_acc | pend_q);
  assign wr_idx        = pend_q ? pend_idx_q : cmd_idx;
  assign {head_data, head_mask} = fifo_mem[rd_ptr_q];
  assign unused_ok     = ^{app_wdf_end, app_addr};

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    pend_d = pend_q;
    // A write accepted without a pop can only mean the FIFO was empty.
    if (pop)         pend_d = 1'b0;
    else if (wr_acc) pend_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cal_cnt_q  <= '0;
      calib_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      if (!calib_q) begin
        if (cal_cnt_q == CAL_LAST) calib_q <= 1'b1;
        cal_cnt_q <= cal_cnt_q + 8'd1;
      end
      count_q <= count_d;
      pend_q  <= pend_d;
      if (wr_acc && !fifo_nonempty) pend_idx_q <= cmd_idx;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= {app_wdf_data, app_wdf_mask};
  end

  // One RAM per byte lane so the mask maps straight onto per-lane write enables.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] rd_byte_q;
      always_ff @(posedge clock) begin
        if (pop && !head_mask[gi]) lane_mem[wr_idx] <= head_data[gi*8 +: 8];
        if (rd_acc) rd_byte_q <= lane_mem[cmd_idx];
      end
      assign rd_word[gi*8 +: 8] = rd_byte_q;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      for (int k = 1; k < RD_LATENCY; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign rd_data_last = rd_word;
    end else begin : g_latn
      logic [127:0] dly_q [RD_LATENCY-1];
      always_ff @(posedge clock) begin
        dly_q[0] <= rd_word;
        for (int k = 1; k < RD_LATENCY - 1; k++) dly_q[k] <= dly_q[k-1];
      end
      assign rd_data_last = dly_q[RD_LATENCY-2];
    end
  endgenerate

  assign app_rd_data_valid = ~reset & vld_q[RD_LATENCY-1];
  assign app_rd_data_end   = app_rd_data_valid;
  assign app_rd_data       = app_rd_data_valid ? rd_data_last : '0;

endmodule

// File: tb/tb_mig_ui_model.sv
// Directed plus randomized bench for mig_ui_model against a queue-based reference model.
module tb_mig_ui_model;

  localparam int CAL = 16;
  localparam int LAT = 4;
  localparam int WDF = 4;
  localparam int DL2 = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [26:0]  app_addr = '0;
  logic [2:0]   app_cmd = 3'b111;
  logic         app_en = 1'b0;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         stall = 1'b0;
  logic         app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete;
  logic [127:0] app_rd_data;

  always #5 clock = ~clock;

  mig_ui_model #(.DEPTH_LOG2(DL2), .RD_LATENCY(LAT), .CALIB_CYCLES(CAL), .WDF_DEPTH(WDF)) dut (
    .clock(clock), .reset(reset), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .stall(stall), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete)
  );

  typedef struct {
    longint       due;
    logic [127:0] data;
  } rd_t;

  logic [127:0] mem_m [1 << DL2];
  logic [143:0] fifo_m [$];
  rd_t          rdq [$];
  bit           pend_m = 1'b0;
  int           pend_idx_m = 0;
  int           since_m = 0;
  longint       cyc = 0;
  bit           primed = 1'b0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [143:0] ent, input int a);
    for (int b = 0; b < 16; b++)
      if (!ent[b]) mem_m[a][b*8 +: 8] = ent[16 + b*8 +: 8];
  endtask

  // One clock cycle: drive, compare against model expectations, then advance the model.
  task automatic step(input logic rst, input logic stl, input logic en, input logic [2:0] cmd,
                      input logic [26:0] addr, input logic wren, input logic [127:0] d,
                      input logic [15:0] m);
    bit e_cal, e_rdy, e_wrdy, e_vld, nonempty, wr_acc, rd_acc, push, pop;
    logic [127:0] e_data;
    int idx;
    rd_t r;
    @(negedge clock);
    reset = rst; stall = stl; app_en = en; app_cmd = cmd; app_addr = addr;
    app_wdf_wren = wren; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = wren;
    #1;
    e_cal  = !rst && since_m >= CAL;
    e_wrdy = e_cal && fifo_m.size() < WDF;
    e_rdy  = e_cal && !stl && !pend_m;
    e_vld  = !rst && rdq.size() > 0 && rdq[0].due == cyc;
    e_data = e_vld ? rdq[0].data : '0;
    if (primed) begin
      chk("calib", 128'(init_calib_complete), 128'(e_cal));
      chk("app_rdy", 128'(app_rdy), 128'(e_rdy));
      chk("wdf_rdy", 128'(app_wdf_rdy), 128'(e_wrdy));
      chk("rd_valid", 128'(app_rd_data_valid), 128'(e_vld));
      chk("rd_end", 128'(app_rd_data_end), 128'(e_vld));
      chk("rd_data", app_rd_data, e_data);
    end
    if (e_vld) void'(rdq.pop_front());
    @(posedge clock);
    if (rst) begin
      fifo_m.delete();
      rdq.delete();
      pend_m  = 1'b0;
      since_m = 0;
      primed  = 1'b1;
    end else begin
      idx      = int'(addr[DL2+3:4]);
      nonempty = fifo_m.size() > 0;
      wr_acc   = en && e_rdy && cmd == 3'b000;
      rd_acc   = en && e_rdy && cmd == 3'b001;
      push     = wren && e_wrdy;
      if (rd_acc) begin
        r.due  = cyc + LAT;
        r.data = mem_m[idx];
        rdq.push_back(r);
      end
      pop = nonempty && (wr_acc || pend_m);
      if (pop) begin
        write_mem(fifo_m.pop_front(), wr_acc ? idx : pend_idx_m);
        pend_m = 1'b0;
      end else if (wr_acc) begin
        pend_m     = 1'b1;
        pend_idx_m = idx;
      end
      if (push) fifo_m.push_back({d, m});
      since_m++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'b111, '0, 1'b0, '0, '0);
  endtask

  task automatic cmd_w(input logic [26:0] a);
    step(1'b0, 1'b0, 1'b1, 3'b000, a, 1'b0, '0, '0);
  endtask

  task automatic cmd_r(input logic [26:0] a);
    step(1'b0, 1'b0, 1'b1, 3'b001, a, 1'b0, '0, '0);
  endtask

  task automatic push_d(input logic [127:0] d, input logic [15:0] m);
    step(1'b0, 1'b0, 1'b0, 3'b111, '0, 1'b1, d, m);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [26:0] a;
    for (int i = 0; i < (1 << DL2); i++) mem_m[i] = '0;

    // Reset then calibration: ready signals must rise exactly 16 cycles after release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'b111, '0, 1'b0, '0, '0);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1, 3'b001, 27'h40, 1'b1, rnd128(), '0);
    while (fifo_m.size() > 0) cmd_w(27'h200);
    idle(6);

    // Masked write of DEADBEEF to 0x40, then read it back.
    push_d({$urandom, $urandom, $urandom, 32'hDEADBEEF}, 16'hFFF0);
    cmd_w(27'h40);
    cmd_r(27'h40);
    idle(6);

    // Write command ahead of its data: pending slot holds app_rdy low until the pop.
    cmd_w(27'h80);
    idle(2);
    push_d(rnd128(), 16'h0000);
    idle(2);
    cmd_r(27'h80);
    idle(6);

    // Fill the FIFO, then drain it one write at a time.
    for (int i = 0; i < 4; i++) push_d(rnd128(), 16'(i * 16'h1111));
    idle(2);
    for (int i = 0; i < 4; i++) begin
      cmd_w(27'h100 + 27'(i * 16));
      idle(1);
    end

    // Address wrap and back-to-back reads.
    push_d(rnd128(), 16'h0000);
    cmd_w(27'h0);
    cmd_r(27'h0);
    cmd_r(27'h4000);
    cmd_r(27'h4_C10F);
    idle(6);

    // Reset with two reads in flight; memory must survive.
    cmd_r(27'h40);
    cmd_r(27'h80);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 3'b111, '0, 1'b0, '0, '0);
    idle(18);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 3'b001, 27'h40, 1'b0, '0, '0);
    cmd_r(27'h40);
    cmd_r(27'h80);
    cmd_r(27'h110);
    idle(6);

    // Randomized traffic over a small set of words, with aliased upper address bits.
    for (int i = 0; i < 3000; i++) begin
      a = {13'($urandom), 6'd0, 4'($urandom_range(0, 7)), 4'($urandom)};
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
           ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1)),
           a, 1'($urandom), rnd128(),
           ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
